// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every N_IN-bit vector, holds it SETTLE_CYCLES,
// then samples dut_y against TRUTH_TABLE and accumulates error/first-failure results.
module truth_table_sweeper #(
    parameter int                 N_IN          = 4,
    parameter logic [2**N_IN-1:0] TRUTH_TABLE   = 16'h6996,
    parameter int                 SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_y,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    localparam int              CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  LAST_VEC    = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Everything that survives an abort for post-mortem debug.
    typedef struct packed {
        logic [N_IN:0]   err_count;
        logic [N_IN-1:0] first_vec;
        logic            first_valid;
    } result_t;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  vec_q;
    logic [CNT_W-1:0] settle_cnt;
    result_t          res_q;
    logic             pass_q;

    logic mismatch;
    logic last_vec;
    logic settle_last;

    assign mismatch    = (dut_y != TRUTH_TABLE[vec_q]);
    assign last_vec    = (vec_q == LAST_VEC);
    assign settle_last = (settle_cnt == SETTLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) state_d = DRIVE;
                DRIVE:      if (settle_last) state_d = SAMPLE;
                SAMPLE:     state_d = last_vec ? DONE : DRIVE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy            = (state_q == DRIVE) || (state_q == SAMPLE);
        done            = (state_q == DONE);
        pass            = pass_q;
        vec_out         = vec_q;
        err_count       = res_q.err_count;
        first_err_vec   = res_q.first_vec;
        first_err_valid = res_q.first_valid;
    end

    // Abort leaves res_q untouched so the partial result can still be inspected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q      <= '0;
            settle_cnt <= '0;
            res_q      <= '0;
            pass_q     <= 1'b0;
        end else if (abort) begin
            vec_q      <= '0;
            settle_cnt <= '0;
            pass_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        vec_q      <= '0;
                        settle_cnt <= '0;
                        res_q      <= '0;
                        pass_q     <= 1'b0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_last ? '0 : settle_cnt + CNT_W'(1);
                end
                SAMPLE: begin
                    if (mismatch) begin
                        res_q.err_count <= res_q.err_count + (N_IN+1)'(1);
                        if (!res_q.first_valid) begin
                            res_q.first_vec   <= vec_q;
                            res_q.first_valid <= 1'b1;
                        end
                    end
                    // err_count is wide enough that a mismatch never wraps it to zero.
                    if (last_vec) pass_q <= !mismatch && (res_q.err_count == '0);
                    else          vec_q  <= vec_q + N_IN'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
